da2_multi: RTL and testbench

DA2_MULTI -- requirements
Module: da2_multi

---
 rtl/da2_multi.sv | 141 ++++++++++++++
 tb/tb_da2_multi.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/da2_multi.sv
// rtl/da2_multi.sv - multi-channel serial DAC frame driver sharing sclk/sync
module da2_multi #(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 12,
  parameter int CLK_DIV  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] value,
  input  logic [CHANNELS*2-1:0]      chmode,
  output logic                       sclk,
  output logic                       sync,
  output logic [CHANNELS-1:0]        sdata,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   div_cnt, div_cnt_n;
  logic            half, half_n;
  logic [3:0]      bit_cnt, bit_cnt_n;
  logic [15:0]     shreg   [CHANNELS];
  logic [15:0]     shreg_n [CHANNELS];
  logic [15:0]     frame   [CHANNELS];
  logic            tick;
  logic            accept;

  logic                sclk_d, sync_d, in_ready_d, busy_d, frame_done_d;
  logic [CHANNELS-1:0] sdata_d;

  // half is 0 for the low sclk half in SHIFT and the first half of GAP
  assign tick   = (div_cnt == DIV_LAST);
  assign accept = in_valid & in_ready;

  // build each 16-bit channel word: 00, mode, sample left-justified in 12 bits
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      frame[k]               = '0;
      frame[k][13:12]        = chmode[2*k +: 2];
      frame[k][11 -: DATA_W] = value[k*DATA_W +: DATA_W];
    end
  end

  // state, divider, bit counter and shift-register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      half    <= 1'b0;
      bit_cnt <= '0;
      for (int k = 0; k < CHANNELS; k++) shreg[k] <= '0;
    end else begin
      state   <= state_n;
      div_cnt <= div_cnt_n;
      half    <= half_n;
      bit_cnt <= bit_cnt_n;
      for (int k = 0; k < CHANNELS; k++) shreg[k] <= shreg_n[k];
    end
  end

  // next-state logic: divider ticks pace LOAD, each sclk half and each GAP half
  always_comb begin
    state_n   = state;
    div_cnt_n = tick ? '0 : div_cnt + 1'b1;
    half_n    = half;
    bit_cnt_n = bit_cnt;
    for (int k = 0; k < CHANNELS; k++) shreg_n[k] = shreg[k];
    case (state)
      IDLE: begin
        div_cnt_n = '0;
        half_n    = 1'b0;
        bit_cnt_n = '0;
        if (accept) begin
          state_n = LOAD;
          for (int k = 0; k < CHANNELS; k++) shreg_n[k] = frame[k];
        end
      end
      LOAD: begin
        if (tick) state_n = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          if (!half) begin
            // sclk rises here, so this is the only place the data advances
            half_n = 1'b1;
            for (int k = 0; k < CHANNELS; k++) shreg_n[k] = {shreg[k][14:0], 1'b0};
          end else begin
            half_n = 1'b0;
            if (bit_cnt == 4'd15) state_n = GAP;
            else bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          half_n = ~half;
          if (half) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // output decode from the next state so every output comes straight from a flop
  always_comb begin
    sclk_d       = !(state_n == SHIFT && !half_n);
    sync_d       = !(state_n == LOAD || state_n == SHIFT);
    in_ready_d   = (state_n == IDLE);
    busy_d       = (state_n != IDLE);
    frame_done_d = (state == GAP) && (state_n == IDLE);
    for (int k = 0; k < CHANNELS; k++)
      sdata_d[k] = (state_n == LOAD || state_n == SHIFT) ? shreg_n[k][15] : 1'b0;
  end

  // output registers; reset forces the bus idle at once to abort any frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk       <= 1'b1;
      sync       <= 1'b1;
      sdata      <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      sclk       <= sclk_d;
      sync       <= sync_d;
      sdata      <= sdata_d;
      in_ready   <= in_ready_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_da2_multi.sv
// tb/tb_da2_multi.sv - directed bench for da2_multi on three parameter sets
module tb_da2_multi;

  logic clk;
  int   total, bad;

  logic        a_rst_n, a_in_valid, a_in_ready, a_sclk, a_sync, a_busy, a_frame_done;
  logic [23:0] a_value;
  logic [3:0]  a_chmode;
  logic [1:0]  a_sdata;

  logic        b_rst_n, b_in_valid, b_in_ready, b_sclk, b_sync, b_busy, b_frame_done;
  logic [15:0] b_value;
  logic [3:0]  b_chmode;
  logic [1:0]  b_sdata;

  logic        c_rst_n, c_in_valid, c_in_ready, c_sclk, c_sync, c_busy, c_frame_done;
  logic [95:0] c_value;
  logic [15:0] c_chmode;
  logic [7:0]  c_sdata;

  int          sel;
  logic        s_sclk, s_sync;
  logic [7:0]  s_sdata;
  logic [15:0] cap_fr [8];
  int          cap_falls, cap_low, cap_unstable;

  da2_multi #(.CHANNELS(2), .DATA_W(12), .CLK_DIV(2)) u_a (
    .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .value(a_value), .chmode(a_chmode), .sclk(a_sclk), .sync(a_sync),
    .sdata(a_sdata), .busy(a_busy), .frame_done(a_frame_done));

  da2_multi #(.CHANNELS(2), .DATA_W(8), .CLK_DIV(1)) u_b (
    .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .value(b_value), .chmode(b_chmode), .sclk(b_sclk), .sync(b_sync),
    .sdata(b_sdata), .busy(b_busy), .frame_done(b_frame_done));

  da2_multi #(.CHANNELS(8), .DATA_W(12), .CLK_DIV(3)) u_c (
    .clk(clk), .rst_n(c_rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .value(c_value), .chmode(c_chmode), .sclk(c_sclk), .sync(c_sync),
    .sdata(c_sdata), .busy(c_busy), .frame_done(c_frame_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    s_sclk  = c_sclk;
    s_sync  = c_sync;
    s_sdata = c_sdata;
    if (sel == 0) begin
      s_sclk = a_sclk; s_sync = a_sync; s_sdata = {6'b0, a_sdata};
    end else if (sel == 1) begin
      s_sclk = b_sclk; s_sync = b_sync; s_sdata = {6'b0, b_sdata};
    end
  end

  // called at the first negedge with sync low; returns at first negedge with sync high
  task automatic capture();
    logic       ps;
    logic [7:0] pd;
    int         n;
    for (int k = 0; k < 8; k++) cap_fr[k] = '0;
    cap_falls = 0; cap_low = 0; cap_unstable = 0;
    ps = s_sclk; pd = s_sdata; n = 0;
    while (s_sync == 1'b0 && n < 2000) begin
      if (ps && !s_sclk) begin
        for (int k = 0; k < 8; k++) cap_fr[k] = {cap_fr[k][14:0], s_sdata[k]};
        cap_falls++;
        if (s_sdata !== pd) cap_unstable++;
      end
      ps = s_sclk; pd = s_sdata; cap_low++; n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if ({a_sclk, a_sync, a_busy, a_in_ready, a_frame_done, a_sdata} !== 7'b1100000) begin
      bad++; $display("FAIL reset_a got=%b want=1100000", {a_sclk, a_sync, a_busy, a_in_ready, a_frame_done, a_sdata}); end
    total++; if ({b_sclk, b_sync, b_busy, b_in_ready, b_frame_done, b_sdata} !== 7'b1100000) begin
      bad++; $display("FAIL reset_b got=%b want=1100000", {b_sclk, b_sync, b_busy, b_in_ready, b_frame_done, b_sdata}); end
    total++; if ({c_sclk, c_sync, c_busy, c_in_ready, c_frame_done, c_sdata} !== 13'b1100000000000) begin
      bad++; $display("FAIL reset_c got=%b want=1100000000000", {c_sclk, c_sync, c_busy, c_in_ready, c_frame_done, c_sdata}); end
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
    @(negedge clk);
    total++; if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b111) begin
      bad++; $display("FAIL reset_release_ready got=%b want=111", {a_in_ready, b_in_ready, c_in_ready}); end
    total++; if ({a_busy, a_sync, a_sclk} !== 3'b011) begin
      bad++; $display("FAIL reset_release_idle got=%b want=011", {a_busy, a_sync, a_sclk}); end
  endtask

  task automatic test_frame_basic();
    sel = 0;
    a_value = {12'hFFF, 12'h5A5}; a_chmode = 4'b0000; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    total++; if ({a_sync, a_in_ready, a_busy, a_sclk} !== 4'b0011) begin
      bad++; $display("FAIL basic_load got=%b want=0011", {a_sync, a_in_ready, a_busy, a_sclk}); end
    capture();
    total++; if (cap_fr[0] !== 16'h05A5) begin bad++; $display("FAIL basic_ch0 got=%h want=05a5", cap_fr[0]); end
    total++; if (cap_fr[1] !== 16'h0FFF) begin bad++; $display("FAIL basic_ch1 got=%h want=0fff", cap_fr[1]); end
    total++; if (cap_falls !== 16) begin bad++; $display("FAIL basic_falls got=%0d want=16", cap_falls); end
    total++; if (cap_low !== 66) begin bad++; $display("FAIL basic_sync_low got=%0d want=66", cap_low); end
    total++; if ({a_sclk, a_sdata, a_busy} !== 4'b1001) begin
      bad++; $display("FAIL basic_gap got=%b want=1001", {a_sclk, a_sdata, a_busy}); end
    repeat (3) @(negedge clk);
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_early got=%b want=0", a_in_ready); end
    @(negedge clk);
    total++; if ({a_in_ready, a_frame_done, a_busy} !== 3'b110) begin
      bad++; $display("FAIL basic_done got=%b want=110", {a_in_ready, a_frame_done, a_busy}); end
    @(negedge clk);
    total++; if ({a_in_ready, a_frame_done} !== 2'b10) begin
      bad++; $display("FAIL basic_done_pulse got=%b want=10", {a_in_ready, a_frame_done}); end
  endtask

  task automatic test_mode_pad();
    sel = 1;
    b_value = {8'h5A, 8'hC3}; b_chmode = {2'b11, 2'b10}; b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    capture();
    total++; if (cap_fr[0] !== 16'h2C30) begin bad++; $display("FAIL pad_ch0 got=%h want=2c30", cap_fr[0]); end
    total++; if (cap_fr[1] !== 16'h35A0) begin bad++; $display("FAIL pad_ch1 got=%h want=35a0", cap_fr[1]); end
    total++; if (cap_low !== 33) begin bad++; $display("FAIL pad_sync_low got=%0d want=33", cap_low); end
    total++; if (cap_unstable !== 0) begin bad++; $display("FAIL pad_unstable got=%0d want=0", cap_unstable); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int   starts [4];
    int   ns, fd, rdy;
    logic ps;
    ns = 0; fd = 0; rdy = 0; ps = 1'b1;
    b_value = {8'h81, 8'h7E}; b_chmode = 4'b0000; b_in_valid = 1'b1;
    for (int t = 0; t <= 110; t++) begin
      if (t > 0) @(negedge clk);
      if (ps && !b_sync && ns < 4) begin starts[ns] = t; ns++; end
      if (b_frame_done) fd++;
      if (t >= 2 && t < 108 && b_in_ready) rdy++;
      if (ns == 3) b_in_valid = 1'b0;
      ps = b_sync;
    end
    total++; if (ns !== 3) begin bad++; $display("FAIL b2b_starts got=%0d want=3", ns); end
    if (ns >= 3) begin
      total++; if (starts[1] - starts[0] !== 36) begin bad++; $display("FAIL b2b_gap1 got=%0d want=36", starts[1] - starts[0]); end
      total++; if (starts[2] - starts[1] !== 36) begin bad++; $display("FAIL b2b_gap2 got=%0d want=36", starts[2] - starts[1]); end
    end
    total++; if (fd !== 3) begin bad++; $display("FAIL b2b_done got=%0d want=3", fd); end
    total++; if (rdy !== 2) begin bad++; $display("FAIL b2b_ready_cycles got=%0d want=2", rdy); end
  endtask

  task automatic test_reset_mid();
    int   falls;
    logic ps;
    falls = 0;
    a_value = {12'h3C3, 12'h0F0}; a_chmode = 4'b0000; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    ps = a_sclk;
    for (int n = 0; n < 200 && falls < 7; n++) begin
      @(negedge clk);
      if (ps && !a_sclk) falls++;
      ps = a_sclk;
    end
    total++; if ({a_sclk, a_sync} !== 2'b00) begin bad++; $display("FAIL mid_pre got=%b want=00", {a_sclk, a_sync}); end
    #2 a_rst_n = 1'b0;
    #1;
    total++; if ({a_sync, a_sclk, a_busy, a_in_ready, a_sdata} !== 6'b110000) begin
      bad++; $display("FAIL mid_abort got=%b want=110000", {a_sync, a_sclk, a_busy, a_in_ready, a_sdata}); end
    @(negedge clk);
    a_rst_n = 1'b1;
    @(negedge clk);
    total++; if ({a_in_ready, a_busy, a_sync, a_sclk} !== 4'b1011) begin
      bad++; $display("FAIL mid_release got=%b want=1011", {a_in_ready, a_busy, a_sync, a_sclk}); end
  endtask

  task automatic test_ignore_shift();
    int low, fd;
    sel = 0; low = 0; fd = 0;
    a_value = {12'h123, 12'hABC}; a_chmode = {2'b01, 2'b00}; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    fork
      capture();
      begin
        repeat (20) @(negedge clk);
        #2; a_value = {12'h000, 12'h555}; a_chmode = 4'b1111; a_in_valid = 1'b1;
        repeat (4) @(negedge clk);
        #2 a_in_valid = 1'b0;
      end
    join
    total++; if (cap_fr[0] !== 16'h0ABC) begin bad++; $display("FAIL ign_ch0 got=%h want=0abc", cap_fr[0]); end
    total++; if (cap_fr[1] !== 16'h1123) begin bad++; $display("FAIL ign_ch1 got=%h want=1123", cap_fr[1]); end
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!a_sync) low++;
      if (a_frame_done) fd++;
    end
    total++; if (low !== 0) begin bad++; $display("FAIL ign_second_frame got=%0d want=0", low); end
    total++; if (fd !== 1) begin bad++; $display("FAIL ign_done got=%0d want=1", fd); end
  endtask

  task automatic test_wide();
    logic [15:0] exp_fr [8];
    logic [11:0] v;
    logic [1:0]  m;
    sel = 2;
    for (int it = 0; it < 2; it++) begin
      for (int k = 0; k < 8; k++) begin
        v = 12'($urandom_range(0, 4095));
        m = 2'($urandom_range(0, 3));
        c_value[k*12 +: 12] = v;
        c_chmode[2*k +: 2]  = m;
        exp_fr[k] = {2'b00, m, v};
      end
      c_in_valid = 1'b1;
      @(negedge clk);
      c_in_valid = 1'b0;
      capture();
      for (int k = 0; k < 8; k++) begin
        total++; if (cap_fr[k] !== exp_fr[k]) begin
          bad++; $display("FAIL wide_ch%0d got=%h want=%h", k, cap_fr[k], exp_fr[k]); end
      end
      total++; if (cap_falls !== 16) begin bad++; $display("FAIL wide_falls got=%0d want=16", cap_falls); end
      total++; if (cap_low !== 99) begin bad++; $display("FAIL wide_sync_low got=%0d want=99", cap_low); end
      total++; if (cap_unstable !== 0) begin bad++; $display("FAIL wide_unstable got=%0d want=0", cap_unstable); end
      repeat (10) @(negedge clk);
    end
  endtask

  initial begin
    total = 0; bad = 0; sel = 0;
    a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    a_value = '0; b_value = '0; c_value = '0;
    a_chmode = '0; b_chmode = '0; c_chmode = '0;
    test_reset();
    test_frame_basic();
    test_mode_pad();
    test_back_to_back();
    test_reset_mid();
    test_ignore_shift();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
